// File: rtl/pwm_dac_if.sv
// Sample stream handshake between the waveform source (master) and the PWM DAC (slave).
interface pwm_dac_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] sample;
  logic             sampleValid;
  logic             sampleReady;

  modport master (output sample, output sampleValid, input  sampleReady);
  modport slave  (input  sample, input  sampleValid, output sampleReady);
endinterface

// File: rtl/pwm_dac.sv
// PWM DAC: FIFO-buffered samples, each rendered as one 2^WIDTH-clock PWM frame.
// Optional saturating underrun counter enabled by defining PWM_DAC_UNDERRUN_CNT_EN.
module pwm_dac #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int LW    = $clog2(DEPTH + 1),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  pwm_dac_if.slave      bus,
  output logic          o_pwmOut,
  output logic [LW-1:0] o_level,
  output logic          o_underrun
`ifdef PWM_DAC_UNDERRUN_CNT_EN
  ,
  output logic [15:0]   o_underrunCount
`endif
);

  logic [WIDTH-1:0] r_frameCnt;
  logic [WIDTH-1:0] r_duty;
  logic             r_pwm;
  logic             r_underrun;
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [LW-1:0]    r_level;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic             w_boundary;
  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_frameNext;
  logic [WIDTH-1:0] w_dutyNext;

  // Ready comes only from registered occupancy, so a pop in the same cycle never admits a push.
  assign w_boundary  = (r_frameCnt == {WIDTH{1'b1}});
  assign w_empty     = (r_level == '0);
  assign w_full      = (r_level == LW'(DEPTH));
  assign w_push      = bus.sampleValid && !w_full;
  assign w_pop       = w_boundary && !w_empty;
  assign w_frameNext = r_frameCnt + 1'b1;
  assign w_dutyNext  = w_pop ? r_mem[r_rdPtr] : r_duty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frameCnt <= '0;
      r_duty     <= '0;
      r_pwm      <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_frameCnt <= w_frameNext;
      r_duty     <= w_dutyNext;
      r_pwm      <= (w_frameNext < w_dutyNext);
      r_underrun <= w_boundary && w_empty;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (w_pop && !w_push) r_level <= r_level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr] <= bus.sample;
  end

`ifdef PWM_DAC_UNDERRUN_CNT_EN
  logic [15:0] r_underrunCnt;

  // Counts on the same edge that raises the underrun pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_underrunCnt <= '0;
    end else if (w_boundary && w_empty && (r_underrunCnt != 16'hFFFF)) begin
      r_underrunCnt <= r_underrunCnt + 16'd1;
    end
  end

  assign o_underrunCount = r_underrunCnt;
`endif

  assign bus.sampleReady = !w_full;
  assign o_pwmOut        = r_pwm;
  assign o_level         = r_level;
  assign o_underrun      = r_underrun;

endmodule

// File: tb/tb_pwm_dac.sv
// Self-checking bench for pwm_dac: frame-level reference model plus directed frame measurements.
module tb_pwm_dac;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int FRAME = 256;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       o_pwmOut;
  logic [2:0] o_level;
  logic       o_underrun;
`ifdef PWM_DAC_UNDERRUN_CNT_EN
  logic [15:0] o_underrunCount;
`endif

  pwm_dac_if #(.WIDTH(WIDTH)) bus ();

  pwm_dac #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .o_pwmOut   (o_pwmOut),
    .o_level    (o_level),
    .o_underrun (o_underrun)
`ifdef PWM_DAC_UNDERRUN_CNT_EN
    ,
    .o_underrunCount (o_underrunCount)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: a queue of pending samples, the position within the frame and the frame's duty.
  logic [7:0] q[$];
  int         mPos = 0;
  int         mDuty = 0;
  int         mUnder = 0;
  int         mUCnt = 0;
  logic       mAccept;
  logic       mPwm;

  assign mPwm = (mPos < mDuty);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      mPos = 0;
      mDuty = 0;
      mUnder = 0;
      mUCnt = 0;
    end else begin
      mAccept = bus.sampleValid && (q.size() < DEPTH);
      mUnder = 0;
      if (mPos == FRAME - 1) begin
        if (q.size() > 0) mDuty = int'(q.pop_front());
        else begin
          mUnder = 1;
          if (mUCnt != 65535) mUCnt++;
        end
      end
      mPos = (mPos + 1) % FRAME;
      if (mAccept) q.push_back(bus.sample);
    end
  end

  always @(negedge clk) begin
    checkOutput("cyclePwm", int'(o_pwmOut), int'(mPwm));
    checkOutput("cycleLevel", int'(o_level), q.size());
    checkOutput("cycleReady", int'(bus.sampleReady), int'(q.size() != DEPTH));
    checkOutput("cycleUnderrun", int'(o_underrun), mUnder);
`ifdef PWM_DAC_UNDERRUN_CNT_EN
    checkOutput("cycleUnderrunCount", int'(o_underrunCount), mUCnt);
`endif
  end

  task automatic applyStimulus(input logic [7:0] s);
    bus.sample = s;
    bus.sampleValid = 1'b1;
    @(negedge clk);
    bus.sampleValid = 1'b0;
  endtask

  task automatic waitPos(input int p);
    int guard = 0;
    while (mPos != p && guard < 2 * FRAME) begin
      @(negedge clk);
      guard++;
    end
    if (mPos != p) begin
      checks++;
      errors++;
      $display("[TB] FAIL waitPos: position %0d, expected %0d", mPos, p);
    end
  endtask

  // Measures one full frame from its first cycle; leaves us at the first cycle of the next frame.
  task automatic countFrame(input string name, input int expHigh, input int expUnder);
    int n = 0;
    int m = 0;
    int u = 0;
    waitPos(0);
    for (int i = 0; i < FRAME; i++) begin
      n += int'(o_pwmOut);
      m += int'(mPwm);
      u += int'(o_underrun);
      @(negedge clk);
    end
    checkOutput({name, " dutHigh"}, n, expHigh);
    checkOutput({name, " modelHigh"}, m, expHigh);
    checkOutput({name, " underruns"}, u, expUnder);
  endtask

  logic [7:0] fill [5];
`ifdef PWM_DAC_UNDERRUN_CNT_EN
  int cntBefore;
`endif

  initial begin
    fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44; fill[4] = 8'h55;
    bus.sample = '0;
    bus.sampleValid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("resetPwm", int'(o_pwmOut), 0);
    checkOutput("resetLevel", int'(o_level), 0);
    checkOutput("resetReady", int'(bus.sampleReady), 1);
    checkOutput("resetUnderrun", int'(o_underrun), 0);
    rst_n = 1'b1;

    $display("[TB] single sample 0x40");
    applyStimulus(8'h40);
    countFrame("frame40", 64, 0);
    checkOutput("levelAfter40", int'(o_level), 0);

    $display("[TB] back-to-back 0x00 0xFF 0x80");
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    applyStimulus(8'h80);
    countFrame("frame00", 0, 0);
    countFrame("frameFF", 255, 0);
    countFrame("frame80", 128, 0);

    $display("[TB] fill to full");
    bus.sampleValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.sample = fill[i];
      @(negedge clk);
    end
    checkOutput("fullLevel", int'(o_level), 4);
    checkOutput("fullReady", int'(bus.sampleReady), 0);
    bus.sample = fill[4];
    waitPos(0);
    checkOutput("afterPopLevel", int'(o_level), 3);
    checkOutput("afterPopReady", int'(bus.sampleReady), 1);
    @(negedge clk);
    bus.sampleValid = 1'b0;
    checkOutput("fifthLevel", int'(o_level), 4);
    checkOutput("fifthReady", int'(bus.sampleReady), 0);
    countFrame("frame22", 34, 0);
    countFrame("frame33", 51, 0);
    countFrame("frame44", 68, 0);
    countFrame("frame55", 85, 0);

    $display("[TB] underrun repeat 0x20");
    applyStimulus(8'h20);
    countFrame("frame20", 32, 0);
`ifdef PWM_DAC_UNDERRUN_CNT_EN
    cntBefore = int'(o_underrunCount);
`endif
    countFrame("frame20repeat", 32, 1);
`ifdef PWM_DAC_UNDERRUN_CNT_EN
    checkOutput("underrunCountStep", int'(o_underrunCount) - cntBefore, 1);
`endif

    $display("[TB] push in boundary cycle");
    waitPos(FRAME - 1);
    bus.sample = 8'h10;
    bus.sampleValid = 1'b1;
    @(negedge clk);
    bus.sampleValid = 1'b0;
    checkOutput("boundaryUnderrun", int'(o_underrun), 1);
    checkOutput("boundaryLevel", int'(o_level), 1);
    countFrame("frame20again", 32, 1);
    countFrame("frame10", 16, 0);

    $display("[TB] reset mid-frame");
    applyStimulus(8'hF0);
    waitPos(0);
    applyStimulus(8'h90);
    applyStimulus(8'hA0);
    waitPos(100);
    checkOutput("preResetPwm", int'(o_pwmOut), 1);
    checkOutput("preResetLevel", int'(o_level), 2);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midResetPwm", int'(o_pwmOut), 0);
    checkOutput("midResetLevel", int'(o_level), 0);
    checkOutput("midResetReady", int'(bus.sampleReady), 1);
    checkOutput("midResetUnderrun", int'(o_underrun), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    countFrame("postResetFrame", 0, 0);
    countFrame("postResetUnderrunFrame", 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
